multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS controller: a Moore-style FSM that sequences the shared-memory, single-ALU datapath of the multicycle CPU across fetch, decode, execute, memory and write-back cycles. It decodes `Op_i` from the instruction register and drives every datapath select and enable. It stalls on a memory ready handshake and counts retired instructions. It sits between the instruction register and the PC, memory, register-file and ALU muxes.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk_i` in 1: clock; all state changes on its rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `Op_i` in 6: opcode field of the instruction register.
- `MemReady_i` in 1: memory has completed the current read or write this cycle.
- `PCWrite_o` out 1: unconditional PC load.
- `PCWriteCond_o` out 1: PC load qualified externally by ALU Zero (beq).
- `IorD_o` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `MemRead_o`, `MemWrite_o` out 1 each: memory strobes.
- `IRWrite_o` out 1: instruction register load.
- `RegDst_o` out 1: 0 = rt, 1 = rd.
- `MemtoReg_o` out 1: 0 = ALUOut, 1 = MDR.
- `RegWrite_o` out 1: register file write enable.
- `ALUSrcA_o` out 1: 0 = PC, 1 = A.
- `ALUSrcB_o` out 2: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `ALUOp_o` out 2: 00 = R-type (funct), 01 = add, 10 = sub.
- `PCSource_o` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Illegal_o` out 1: unsupported opcode seen in DECODE.
- `State_o` out 4: current state encoding, for debug.
- `InstrCount_o` out CNT_W: retired instructions, wraps modulo 2^CNT_W.

## Operation
- State encodings:
  - INIT 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6.
  - EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12.
  - Codes 13–15 are unreachable and go to INIT.
- Default output: every output not listed for a state is 0.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSource=00.
  - IRWrite=1 and PCWrite=1 only while MemReady_i=1. These two are the only Mealy terms here.
  - Leave to DECODE on MemReady_i=1; otherwise hold in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=01 (branch target).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDIEX.
  - Any other opcode: Illegal_o=1 for this cycle, next state FETCH, no retire.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=01. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Advance to MEMWB on MemReady_i; otherwise hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Retire, then FETCH.
- MEMWR: MemWrite=1, IorD=1. On MemReady_i, retire and go to FETCH; otherwise hold.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00. Next is RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Retire, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCWriteCond=1, PCSource=01. Retire, then FETCH.
- JUMP: PCWrite=1, PCSource=10. Retire, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=01. Next is ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Retire, then FETCH.
- Retire: InstrCount_o increments by 1 on the edge that leaves the final state. All-ones wraps to 0.
- `Op_i` is sampled only in DECODE and MEMADR. It may change in any other state without effect.

## Timing
- Reset: rst_i=0 at a rising edge forces state INIT and InstrCount_o=0. This overrides any state, including a memory wait.
  - During and right after reset, all control outputs are 0 and State_o=0.
  - The first FETCH is the cycle after rst_i is sampled 1.
- Cycles from FETCH entry to the next FETCH, with MemReady_i held at 1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle MemReady_i is 0 in FETCH, MEMRD or MEMWR adds one cycle. All outputs stay stable during the wait.
- MemReady_i outside the three memory states is ignored.
- The counter value is visible in the cycle after the retiring edge.

## Test plan
- Reset: hold rst_i=0 for 3 cycles, then release.
  - Required: State_o=0 and all outputs 0 while in reset; State_o=1 with MemRead_o=1 one cycle after release.
- lw (Op_i=100011), MemReady_i=1:
  - Required: State_o sequence 1,2,3,4,5,1.
  - RegWrite_o=1 and MemtoReg_o=1 only in state 5.
  - InstrCount_o goes 0→1.
- sw with MemReady_i=0 for 3 cycles in MEMWR:
  - Required: MemWrite_o=1 and IorD_o=1 held 4 cycles; RegWrite_o never 1; count increments once.
- FETCH wait, MemReady_i=0 for 2 cycles:
  - Required: IRWrite_o=0 and PCWrite_o=0 during the wait; both 1 in exactly the ready cycle.
- Sequence R-type, beq, j, addi, then illegal 111111:
  - Required per-instruction cycle counts 4,3,3,4,2.
  - PCWriteCond_o=1 only in state 9; PCSource_o=10 in state 10.
  - Illegal_o pulses once; final count 4.
- rst_i=0 in MEMRD while waiting, then CNT_W=4 wrap check:
  - Required: reset returns to INIT with count 0.
  - After 16 retired j instructions, count returns to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing the shared-memory,
// single-ALU datapath through fetch/decode/execute/memory/write-back.
// Ports:
//   clk_i, rst_i (sync, active-low)   - clock and reset
//   Op_i                              - opcode from the instruction register
//   MemReady_i                        - memory completes the current access
//   PCWrite_o .. PCSource_o           - datapath selects and enables
//   Illegal_o                         - unsupported opcode seen in DECODE
//   State_o                           - current state encoding (debug)
//   InstrCount_o                      - retired instructions, wraps
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       Op_i,
    input  logic             MemReady_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             RegDst_o,
    output logic             MemtoReg_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       PCSource_o,
    output logic             Illegal_o,
    output logic [3:0]       State_o,
    output logic [CNT_W-1:0] InstrCount_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       retire;
    logic [CNT_W-1:0] instr_count;

    // State register and retired-instruction counter
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_INIT;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode; FETCH IRWrite/PCWrite follow MemReady_i
    always_comb begin
        state_next    = state;
        retire        = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        PCSource_o    = 2'b00;
        Illegal_o     = 1'b0;

        case (state)
            S_INIT: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALUOp_o   = 2'b01;
                IRWrite_o = MemReady_i;
                PCWrite_o = MemReady_i;
                if (MemReady_i) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                ALUOp_o   = 2'b01;
                case (Op_i)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default: begin
                        Illegal_o  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o  = 1'b1;
                ALUSrcB_o  = 2'b10;
                ALUOp_o    = 2'b01;
                state_next = (Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (MemReady_i) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (MemReady_i) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA_o  = 1'b1;
                state_next = S_RWB;
            end
            S_RWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b10;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                retire        = 1'b1;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA_o  = 1'b1;
                ALUSrcB_o  = 2'b10;
                ALUOp_o    = 2'b01;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    assign State_o      = state;
    assign InstrCount_o = instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level driver
// walks each instruction's cycle list and queues the expected per-cycle
// response; a monitor pops and compares once per cycle on the falling edge.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic             clk;
    logic             rst_n;
    logic [5:0]       op;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit               skip;
        logic [3:0]       st;
        logic [16:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_count;
    bit               drv_done;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .Op_i          (op),
        .MemReady_i    (mem_ready),
        .PCWrite_o     (pc_write),
        .PCWriteCond_o (pc_write_cond),
        .IorD_o        (iord),
        .MemRead_o     (mem_read),
        .MemWrite_o    (mem_write),
        .IRWrite_o     (ir_write),
        .RegDst_o      (reg_dst),
        .MemtoReg_o    (mem_to_reg),
        .RegWrite_o    (reg_write),
        .ALUSrcA_o     (alu_src_a),
        .ALUSrcB_o     (alu_src_b),
        .ALUOp_o       (alu_op),
        .PCSource_o    (pc_source),
        .Illegal_o     (illegal),
        .State_o       (state),
        .InstrCount_o  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word expected in each architectural phase
    function automatic logic [16:0] exp_ctrl(int st, bit rdy, bit ill);
        logic pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa, il;
        logic [1:0] sbv, aop, pcs;
        {pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa, il} = '0;
        sbv = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            1:  begin mr = 1; sbv = 2'b01; aop = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin sbv = 2'b11; aop = 2'b01; il = ill; end
            3:  begin sa = 1; sbv = 2'b10; aop = 2'b01; end
            4:  begin mr = 1; io = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin sa = 1; end
            8:  begin rd = 1; rw = 1; end
            9:  begin sa = 1; aop = 2'b10; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin sa = 1; sbv = 2'b10; aop = 2'b01; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa, sbv, aop, pcs, il};
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) ||
               (o == OP_BEQ) || (o == OP_J) || (o == OP_ADDI);
    endfunction

    task automatic push_exp(int st, bit rdy, bit ill);
        exp_t e;
        e.skip = 1'b0;
        e.st   = 4'(st);
        e.ctrl = exp_ctrl(st, rdy, ill);
        e.cnt  = exp_count;
        sb.push_back(e);
    endtask

    // Reset held for n cycles, then one released cycle still in INIT
    task automatic do_reset(int n);
        for (int i = 0; i < n + 1; i++) begin
            @(posedge clk); #1;
            rst_n     = (i == n);
            op        = 6'($urandom);
            mem_ready = 1'($urandom);
            exp_count = '0;
            push_exp(0, 1'b0, 1'b0);
        end
    endtask

    // One instruction: fw FETCH waits, mw memory waits; abort_idx >= 0
    // asserts reset in that cycle and abandons the instruction
    task automatic run_instr(logic [5:0] o, int fw, int mw, int abort_idx);
        int  sts[$];
        bit  rdys[$];
        bit  ill;
        ill = !is_legal(o);
        for (int i = 0; i < fw; i++) begin sts.push_back(1); rdys.push_back(0); end
        sts.push_back(1); rdys.push_back(1);
        sts.push_back(2); rdys.push_back(1'($urandom));
        case (o)
            OP_R:    begin sts.push_back(7); rdys.push_back(1'($urandom));
                           sts.push_back(8); rdys.push_back(1'($urandom)); end
            OP_LW:   begin sts.push_back(3); rdys.push_back(1'($urandom));
                           for (int i = 0; i < mw; i++) begin sts.push_back(4); rdys.push_back(0); end
                           sts.push_back(4); rdys.push_back(1);
                           sts.push_back(5); rdys.push_back(1'($urandom)); end
            OP_SW:   begin sts.push_back(3); rdys.push_back(1'($urandom));
                           for (int i = 0; i < mw; i++) begin sts.push_back(6); rdys.push_back(0); end
                           sts.push_back(6); rdys.push_back(1); end
            OP_BEQ:  begin sts.push_back(9); rdys.push_back(1'($urandom)); end
            OP_J:    begin sts.push_back(10); rdys.push_back(1'($urandom)); end
            OP_ADDI: begin sts.push_back(11); rdys.push_back(1'($urandom));
                           sts.push_back(12); rdys.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            @(posedge clk); #1;
            rst_n     = (i != abort_idx);
            mem_ready = rdys[i];
            op        = (sts[i] == 2 || sts[i] == 3) ? o : 6'($urandom);
            push_exp(sts[i], rdys[i], ill);
            if (i == abort_idx) begin
                exp_count = '0;
                return;
            end
        end
        if (!ill) exp_count = exp_count + CNT_W'(1);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.skip) begin
                    checks++;
                    if (state !== e.st) begin
                        errors++;
                        $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
                    end
                    checks++;
                    if ({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                         reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                         pc_source, illegal} !== e.ctrl) begin
                        errors++;
                        $display("FAIL ctrl t=%0t st=%0d got=%b exp=%b", $time, e.st,
                                 {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                                  pc_source, illegal}, e.ctrl);
                    end
                    checks++;
                    if (instr_count !== e.cnt) begin
                        errors++;
                        $display("FAIL count t=%0t got=%0d exp=%0d", $time, instr_count, e.cnt);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] o;
        legal_ops[0] = OP_R;   legal_ops[1] = OP_LW; legal_ops[2] = OP_SW;
        legal_ops[3] = OP_BEQ; legal_ops[4] = OP_J;  legal_ops[5] = OP_ADDI;
        drv_done  = 1'b0;
        rst_n     = 1'b0;
        op        = '0;
        mem_ready = 1'b0;
        exp_count = '0;

        do_reset(3);
        run_instr(OP_LW, 0, 0, -1);
        run_instr(OP_SW, 0, 3, -1);
        run_instr(OP_R, 2, 0, -1);
        run_instr(OP_R, 0, 0, -1);
        run_instr(OP_BEQ, 0, 0, -1);
        run_instr(OP_J, 0, 0, -1);
        run_instr(OP_ADDI, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do begin o = 6'($urandom); end while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        // Reset while lw waits in MEMRD (cycle index 3: FETCH, DECODE, MEMADR, MEMRD)
        run_instr(OP_LW, 0, 3, 3);
        do_reset(2);

        for (int n = 0; n < 16; n++) begin
            run_instr(OP_J, $urandom_range(0, 2), 0, -1);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        push_exp(1, 1'b0, 1'b0);
        drv_done = 1'b1;
    end

    // Wrap check after 16 retirements since the last reset, then summary
    initial begin
        int guard;
        guard = 0;
        while (!(drv_done && sb.size() == 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            errors++;
            $display("FAIL timeout got=%0d cycles exp=<5000", guard);
        end
        @(negedge clk);
        checks++;
        if (instr_count !== exp_count || exp_count !== '0) begin
            errors++;
            $display("FAIL wrap got=%0d exp=0", instr_count);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
